// File: rtl/ttc_broadcast_scheduler.sv
// ttc_broadcast_scheduler
// Generates TTC Channel B broadcast commands locally while the TTC link is in
// loopback. Single-cycle requests (event-count reset, timestamp reset,
// fill-type switch, async pulse storage start/stop) are captured into pending
// slots, arbitrated with fixed priority evt > ts > fill > async, and issued one
// at a time as a one-cycle strobe followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clk, reset        sole clock, synchronous active-high reset
//   sched_enable      1 = may start a new issue, 0 = hold pending requests
//   req_evt_reset     pulse: event count reset request
//   req_ts_reset      pulse: timestamp reset request
//   req_fill          pulse: fill-type switch request, with req_fill_type[4:0]
//   req_async_start   pulse: start async pulse storage
//   req_async_stop    pulse: stop async pulse storage
//   chan_b_info[5:0]  Brcst[7:2] payload, zero when chan_b_valid is low
//   chan_b_valid      one-cycle broadcast strobe
//   evt_count_reset   one-cycle event count reset, coincident with an evt strobe
//   pending[3:0]      {async,fill,ts,evt} pending flags
//   busy              high while issuing or in holdoff
//   merge_count       requests folded into an already-pending slot
//
// Configuration macro: TTC_SCHED_MERGE_CNT_EN enables the saturating
// merge_count counter; when undefined merge_count is tied to zero.

module ttc_broadcast_scheduler #(
  parameter int GAP_CYCLES = 4,
  parameter int MERGE_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sched_enable,
  input  logic               req_evt_reset,
  input  logic               req_ts_reset,
  input  logic               req_fill,
  input  logic [4:0]         req_fill_type,
  input  logic               req_async_start,
  input  logic               req_async_stop,
  output logic [5:0]         chan_b_info,
  output logic               chan_b_valid,
  output logic               evt_count_reset,
  output logic [3:0]         pending,
  output logic               busy,
  output logic [MERGE_W-1:0] merge_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t      state, state_next;
  logic [7:0]  hold_cnt;
  logic [3:0]  pend_q;
  logic [3:0]  req_vec;
  logic [3:0]  grant;
  logic        start_issue;
  logic [4:0]  fill_type_q;
  logic        async_stop_q;
  logic [5:0]  payload_q;
  logic        payload_evt_q;

  // Request vector in pending-flag order and the one-hot grant for an issue
  // starting this cycle; grant is zero unless IDLE, enabled and work pending.
  always_comb begin
    req_vec     = {req_async_start | req_async_stop, req_fill, req_ts_reset, req_evt_reset};
    start_issue = (state == IDLE) && sched_enable && (pend_q != 4'b0000);
    grant       = 4'b0000;
    if (start_issue) begin
      if (pend_q[0])      grant = 4'b0001;
      else if (pend_q[1]) grant = 4'b0010;
      else if (pend_q[2]) grant = 4'b0100;
      else                grant = 4'b1000;
    end
  end

  // Next-state logic: one ISSUE cycle, then GAP_CYCLES of HOLD.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_issue) state_next = ISSUE;
      ISSUE: state_next = HOLD;
      HOLD:  if (hold_cnt == 8'(GAP_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and holdoff counter; the counter restarts at zero on
  // every cycle outside HOLD so each HOLD visit lasts exactly GAP_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
    end
  end

  // Pending slots and stored slot values. A request arriving on the edge its
  // own slot is granted re-pends the slot. Stop beats start on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= 4'b0000;
      fill_type_q  <= 5'd0;
      async_stop_q <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~grant) | req_vec;
      if (req_fill) fill_type_q <= req_fill_type;
      if (req_async_stop)       async_stop_q <= 1'b1;
      else if (req_async_start) async_stop_q <= 1'b0;
    end
  end

  // Payload latched at the IDLE->ISSUE edge from the winning slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      payload_q     <= 6'd0;
      payload_evt_q <= 1'b0;
    end else if (start_issue) begin
      payload_evt_q <= grant[0];
      case (grant)
        4'b0001: payload_q <= 6'b000000;
        4'b0010: payload_q <= 6'b001010;
        4'b0100: payload_q <= {fill_type_q, 1'b1};
        default: payload_q <= async_stop_q ? 6'b100000 : 6'b110000;
      endcase
    end
  end

  assign chan_b_valid    = (state == ISSUE);
  assign chan_b_info     = chan_b_valid ? payload_q : 6'd0;
  assign evt_count_reset = chan_b_valid & payload_evt_q;
  assign pending         = pend_q;
  assign busy            = (state != IDLE);

`ifdef TTC_SCHED_MERGE_CNT_EN
  logic [3:0]         merge_slots;
  logic [2:0]         merge_inc;
  logic [MERGE_W:0]   merge_sum;
  logic [MERGE_W-1:0] merge_q;

  // A merge is a request landing on a slot that stays pending through this
  // edge, plus a discarded start when start and stop arrive together.
  always_comb begin
    merge_slots = pend_q & ~grant & req_vec;
    merge_inc   = 3'(merge_slots[0]) + 3'(merge_slots[1]) + 3'(merge_slots[2])
                + 3'(merge_slots[3]) + 3'(req_async_start & req_async_stop);
    merge_sum   = {1'b0, merge_q} + (MERGE_W + 1)'(merge_inc);
  end

  // Saturating merge counter.
  always_ff @(posedge clk) begin
    if (reset)                merge_q <= '0;
    else if (merge_sum[MERGE_W]) merge_q <= '1;
    else                      merge_q <= merge_sum[MERGE_W-1:0];
  end

  assign merge_count = merge_q;
`else
  assign merge_count = '0;
`endif

endmodule

// File: tb/tb_ttc_broadcast_scheduler.sv
// Directed testbench for ttc_broadcast_scheduler (GAP_CYCLES = 4).
// Observation index i counts posedges after stimulus; outputs are sampled
// 1 time unit after each posedge, requests are driven at the same point.

module tb_ttc_broadcast_scheduler;

  localparam int MERGE_W = 16;

  logic               clk;
  logic               reset;
  logic               sched_enable;
  logic               req_evt_reset;
  logic               req_ts_reset;
  logic               req_fill;
  logic [4:0]         req_fill_type;
  logic               req_async_start;
  logic               req_async_stop;
  logic [5:0]         chan_b_info;
  logic               chan_b_valid;
  logic               evt_count_reset;
  logic [3:0]         pending;
  logic               busy;
  logic [MERGE_W-1:0] merge_count;

  int errors = 0;
  int checks = 0;

  int         strobeIdx[$];
  logic [5:0] strobeInfo[$];
  logic       strobeEcr[$];
  int         adjacent;

`ifdef TTC_SCHED_MERGE_CNT_EN
  localparam int EXP_MERGE_ONE = 1;
`else
  localparam int EXP_MERGE_ONE = 0;
`endif

  ttc_broadcast_scheduler #(.GAP_CYCLES(4), .MERGE_W(MERGE_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .sched_enable    (sched_enable),
    .req_evt_reset   (req_evt_reset),
    .req_ts_reset    (req_ts_reset),
    .req_fill        (req_fill),
    .req_fill_type   (req_fill_type),
    .req_async_start (req_async_start),
    .req_async_stop  (req_async_stop),
    .chan_b_info     (chan_b_info),
    .chan_b_valid    (chan_b_valid),
    .evt_count_reset (evt_count_reset),
    .pending         (pending),
    .busy            (busy),
    .merge_count     (merge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic evt, input logic ts, input logic fill,
                               input logic [4:0] ftype, input logic astart, input logic astop);
    req_evt_reset   = evt;
    req_ts_reset    = ts;
    req_fill        = fill;
    req_fill_type   = ftype;
    req_async_start = astart;
    req_async_stop  = astop;
  endtask

  task automatic applyReset();
    applyStimulus(0, 0, 0, 5'd0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs n edges, recording strobes; requests are cleared after the first
  // edge when clearAfterFirst is set.
  task automatic observe(input int n, input bit clearAfterFirst);
    logic prev;
    strobeIdx.delete();
    strobeInfo.delete();
    strobeEcr.delete();
    adjacent = 0;
    prev = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (clearAfterFirst && i == 1) applyStimulus(0, 0, 0, 5'd0, 0, 0);
      if (chan_b_valid) begin
        strobeIdx.push_back(i);
        strobeInfo.push_back(chan_b_info);
        strobeEcr.push_back(evt_count_reset);
        if (prev) adjacent++;
      end
      prev = chan_b_valid;
    end
  endtask

  initial begin
    sched_enable = 1'b0;
    applyReset();
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(chan_b_valid), 32'd0);
    checkOutput("rst_info", 32'(chan_b_info), 32'd0);
    checkOutput("rst_ecr", 32'(evt_count_reset), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_merge", 32'(merge_count), 32'd0);

    // Test 1: single ts request, strobe two edges later
    $display("[TB] test 1: ts latency");
    sched_enable = 1'b1;
    applyStimulus(0, 1, 0, 5'd0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 5'd0, 0, 0);
    checkOutput("t1_pend", 32'(pending), 32'b0010);
    checkOutput("t1_valid_early", 32'(chan_b_valid), 32'd0);
    tick();
    checkOutput("t1_valid", 32'(chan_b_valid), 32'd1);
    checkOutput("t1_info", 32'(chan_b_info), 32'b001010);
    checkOutput("t1_ecr", 32'(evt_count_reset), 32'd0);
    checkOutput("t1_pend_clr", 32'(pending), 32'd0);
    tick();
    checkOutput("t1_valid_drop", 32'(chan_b_valid), 32'd0);
    checkOutput("t1_busy_hold", 32'(busy), 32'd1);

    // Test 2: three simultaneous requests serialised by priority
    $display("[TB] test 2: priority backlog");
    applyReset();
    sched_enable = 1'b1;
    applyStimulus(1, 1, 1, 5'b00010, 0, 0);
    observe(20, 1'b1);
    checkOutput("t2_count", 32'(strobeIdx.size()), 32'd3);
    if (strobeIdx.size() >= 3) begin
      checkOutput("t2_idx0", 32'(strobeIdx[0]), 32'd2);
      checkOutput("t2_idx1", 32'(strobeIdx[1]), 32'd8);
      checkOutput("t2_idx2", 32'(strobeIdx[2]), 32'd14);
      checkOutput("t2_info0", 32'(strobeInfo[0]), 32'b000000);
      checkOutput("t2_ecr0", 32'(strobeEcr[0]), 32'd1);
      checkOutput("t2_info1", 32'(strobeInfo[1]), 32'b001010);
      checkOutput("t2_ecr1", 32'(strobeEcr[1]), 32'd0);
      checkOutput("t2_info2", 32'(strobeInfo[2]), 32'b000101);
      checkOutput("t2_ecr2", 32'(strobeEcr[2]), 32'd0);
    end

    // Test 3: fill overwrite while disabled, single strobe after enable
    $display("[TB] test 3: fill overwrite");
    applyReset();
    sched_enable = 1'b0;
    applyStimulus(0, 0, 1, 5'b00011, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 5'b00111, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 5'd0, 0, 0);
    observe(8, 1'b0);
    checkOutput("t3_no_strobe_disabled", 32'(strobeIdx.size()), 32'd0);
    checkOutput("t3_pend", 32'(pending), 32'b0100);
    sched_enable = 1'b1;
    observe(20, 1'b0);
    checkOutput("t3_count", 32'(strobeIdx.size()), 32'd1);
    if (strobeIdx.size() >= 1) begin
      checkOutput("t3_idx", 32'(strobeIdx[0]), 32'd1);
      checkOutput("t3_info", 32'(strobeInfo[0]), 32'b001111);
    end
    checkOutput("t3_merge", 32'(merge_count), 32'(EXP_MERGE_ONE));

    // Test 4: async start+stop together, stop wins
    $display("[TB] test 4: async start+stop");
    applyReset();
    sched_enable = 1'b1;
    applyStimulus(0, 0, 0, 5'd0, 1, 1);
    observe(20, 1'b1);
    checkOutput("t4_count", 32'(strobeIdx.size()), 32'd1);
    if (strobeIdx.size() >= 1) begin
      checkOutput("t4_idx", 32'(strobeIdx[0]), 32'd2);
      checkOutput("t4_info", 32'(strobeInfo[0]), 32'b100000);
    end
    checkOutput("t4_merge", 32'(merge_count), 32'(EXP_MERGE_ONE));

    // Test 5: reset during HOLD with fill pending
    $display("[TB] test 5: reset in hold");
    applyReset();
    sched_enable = 1'b1;
    applyStimulus(0, 1, 0, 5'd0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 5'd0, 0, 0);
    tick();
    checkOutput("t5_issue", 32'(chan_b_valid), 32'd1);
    tick();
    applyStimulus(0, 0, 1, 5'b01010, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 5'd0, 0, 0);
    checkOutput("t5_pend_fill", 32'(pending), 32'b0100);
    checkOutput("t5_busy_hold", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_pend", 32'(pending), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_valid", 32'(chan_b_valid), 32'd0);
    checkOutput("t5_info", 32'(chan_b_info), 32'd0);
    observe(15, 1'b0);
    checkOutput("t5_no_strobe", 32'(strobeIdx.size()), 32'd0);

    // Test 6: continuous ts requests, strobes spaced 6 apart
    $display("[TB] test 6: continuous backlog");
    applyReset();
    sched_enable = 1'b1;
    applyStimulus(0, 1, 0, 5'd0, 0, 0);
    observe(100, 1'b0);
    applyStimulus(0, 0, 0, 5'd0, 0, 0);
    checkOutput("t6_adjacent", 32'(adjacent), 32'd0);
    checkOutput("t6_count", 32'(strobeIdx.size()), 32'd17);
    if (strobeIdx.size() >= 1) checkOutput("t6_first", 32'(strobeIdx[0]), 32'd2);
    for (int k = 1; k < strobeIdx.size(); k++)
      checkOutput($sformatf("t6_spacing%0d", k), 32'(strobeIdx[k] - strobeIdx[k-1]), 32'd6);

    // Drain to idle with a bounded wait
    for (int i = 0; i < 50 && busy; i++) tick();
    checkOutput("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
